// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128 key schedule, one round key per cycle.
// After an accepted start it streams K0..K10 on rk_out/rk_round with rk_valid.
// key_done pulses alongside K10. K10 is then held in round_key_10 with
// key_valid until the next accepted start.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   EN                 global enable; 0 freezes the expansion
//   cipher_key_in      128-bit cipher key (bits [127:96] = w0)
//   key_start          start request
//   key_busy           expansion in progress
//   rk_valid           rk_out / rk_round valid this cycle
//   rk_out, rk_round   current round key and its index (0..10)
//   key_done           one-cycle pulse with rk_round = 10
//   round_key_10       K10 of the last completed expansion
//   key_valid          round_key_10 holds a completed expansion
//
// Optional macro AES_KEYEXP_ABORT_EN: a start while busy restarts the expansion.
//
// State | meaning
// IDLE  | waiting for key_start
// EXPAND| presenting K0..K10, one per enabled cycle

module aes_key_expander #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             EN,
  input  logic [KEY_W-1:0] cipher_key_in,
  input  logic             key_start,
  output logic             key_busy,
  output logic             rk_valid,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_round,
  output logic             key_done,
  output logic [KEY_W-1:0] round_key_10,
  output logic             key_valid
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_key_expander: NR must be 10");
  end
  if (KEY_W != 128) begin : g_bad_key_w
    $error("aes_key_expander: KEY_W must be 128");
  end

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_EXPAND = 1'b1;
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] wk_q, wk_d;
  logic         rk_valid_q, rk_valid_d;
  logic [127:0] rk_out_q, rk_out_d;
  logic [3:0]   rk_round_q, rk_round_d;
  logic         key_done_q, key_done_d;
  logic [127:0] rk10_q, rk10_d;
  logic         key_valid_q, key_valid_d;

  // Next round key from the working key (single combinational path).
  logic [31:0]  w0, w1, w2, w3, rot_w, sub_w, temp_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;
  logic [7:0]   rcon_next;
  logic         start_ok;

  always_comb begin
    w0 = wk_q[127:96];
    w1 = wk_q[95:64];
    w2 = wk_q[63:32];
    w3 = wk_q[31:0];
    rot_w  = {w3[23:0], w3[31:24]};
    sub_w  = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]};
    temp_w = sub_w ^ {rcon_q, 24'h0};
    n0 = w0 ^ temp_w;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key  = {n0, n1, n2, n3};
    rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

`ifdef AES_KEYEXP_ABORT_EN
  assign start_ok = EN & key_start;
`else
  assign start_ok = EN & key_start & (state_q == ST_IDLE);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcon_d      = rcon_q;
    wk_d        = wk_q;
    rk_valid_d  = 1'b0;
    rk_out_d    = rk_out_q;
    rk_round_d  = rk_round_q;
    key_done_d  = 1'b0;
    rk10_d      = rk10_q;
    key_valid_d = key_valid_q;
    if (start_ok) begin
      // K0 is the cipher key itself, so it is presented straight from the load.
      state_d     = ST_EXPAND;
      cnt_d       = 4'd0;
      rcon_d      = 8'h01;
      wk_d        = cipher_key_in;
      rk_out_d    = cipher_key_in;
      rk_round_d  = 4'd0;
      rk_valid_d  = 1'b1;
      key_valid_d = 1'b0;
    end else if (state_q == ST_EXPAND && EN) begin
      if (cnt_q == LAST_ROUND) begin
        // K10 was shown this cycle; capture it and release.
        state_d     = ST_IDLE;
        rk10_d      = wk_q;
        key_valid_d = 1'b1;
      end else begin
        wk_d       = next_key;
        rcon_d     = rcon_next;
        cnt_d      = cnt_q + 4'd1;
        rk_out_d   = next_key;
        rk_round_d = cnt_q + 4'd1;
        rk_valid_d = 1'b1;
        key_done_d = (cnt_q == LAST_ROUND - 4'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rcon_q      <= 8'h00;
      wk_q        <= 128'h0;
      rk_valid_q  <= 1'b0;
      rk_out_q    <= 128'h0;
      rk_round_q  <= 4'd0;
      key_done_q  <= 1'b0;
      rk10_q      <= 128'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcon_q      <= rcon_d;
      wk_q        <= wk_d;
      rk_valid_q  <= rk_valid_d;
      rk_out_q    <= rk_out_d;
      rk_round_q  <= rk_round_d;
      key_done_q  <= key_done_d;
      rk10_q      <= rk10_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign key_busy     = (state_q == ST_EXPAND);
  assign rk_valid     = rk_valid_q;
  assign rk_out       = rk_out_q;
  assign rk_round     = rk_round_q;
  assign key_done     = key_done_q;
  assign round_key_10 = rk10_q;
  assign key_valid    = key_valid_q;

endmodule

// File: tb/tb_aes_key_expander.sv
module tb_aes_key_expander;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         EN;
  logic [127:0] cipher_key_in;
  logic         key_start;
  logic         key_busy;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         key_done;
  logic [127:0] round_key_10;
  logic         key_valid;

  int n_total = 0;
  int n_pass  = 0;

  aes_key_expander dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .EN           (EN),
    .cipher_key_in(cipher_key_in),
    .key_start    (key_start),
    .key_busy     (key_busy),
    .rk_valid     (rk_valid),
    .rk_out       (rk_out),
    .rk_round     (rk_round),
    .key_done     (key_done),
    .round_key_10 (round_key_10),
    .key_valid    (key_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_n(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_k(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_b({tag, "_busy"},  key_busy, 1'b0);
    chk_b({tag, "_valid"}, rk_valid, 1'b0);
    chk_k({tag, "_out"},   rk_out, 128'h0);
    chk_n({tag, "_round"}, rk_round, 4'd0);
    chk_b({tag, "_done"},  key_done, 1'b0);
    chk_k({tag, "_rk10"},  round_key_10, 128'h0);
    chk_b({tag, "_kval"},  key_valid, 1'b0);
  endtask

  initial begin
    reset_n = 1'b1; EN = 1'b0; key_start = 1'b0; cipher_key_in = 128'h0;
    #1 reset_n = 1'b0;
    #2;
    chk_all_zero("reset");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // FIPS-197 key: start sampled at end of T, observe from T+1
    EN = 1'b1; cipher_key_in = FIPS_KEY; key_start = 1'b1;
    tick(); key_start = 1'b0;
    chk_k("fips_k0", rk_out, FIPS_KEY);
    chk_n("fips_r0", rk_round, 4'd0);
    chk_b("fips_v0", rk_valid, 1'b1);
    chk_b("fips_busy0", key_busy, 1'b1);
    chk_b("fips_kval0", key_valid, 1'b0);
    tick();
    chk_k("fips_k1", rk_out, FIPS_K1);
    for (int i = 2; i <= 10; i++) begin
      tick();
      chk_n("fips_round", rk_round, 4'(i));
      chk_b("fips_done", key_done, (i == 10));
    end
    chk_k("fips_k10", rk_out, FIPS_K10);
    chk_b("fips_busy10", key_busy, 1'b1);
    tick();
    chk_b("fips_kval12", key_valid, 1'b1);
    chk_k("fips_rk10", round_key_10, FIPS_K10);
    chk_b("fips_busy12", key_busy, 1'b0);
    chk_b("fips_v12", rk_valid, 1'b0);
    chk_b("fips_done12", key_done, 1'b0);
    chk_n("fips_hold_round", rk_round, 4'd10);
    chk_k("fips_hold_out", rk_out, FIPS_K10);

    // All-zero key exercises Rcon 1B and 36
    cipher_key_in = 128'h0; key_start = 1'b1;
    tick(); key_start = 1'b0;
    chk_k("zero_k0", rk_out, 128'h0);
    chk_b("zero_kval_clr", key_valid, 1'b0);
    tick();
    chk_k("zero_k1", rk_out, ZERO_K1);
    repeat (9) tick();
    chk_k("zero_k10", rk_out, ZERO_K10);
    chk_b("zero_done", key_done, 1'b1);
    tick();
    chk_k("zero_rk10", round_key_10, ZERO_K10);

    // Stall of 3 cycles after K4
    cipher_key_in = FIPS_KEY; key_start = 1'b1;
    tick(); key_start = 1'b0;
    repeat (4) tick();
    chk_n("stall_r4", rk_round, 4'd4);
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_b("stall_valid", rk_valid, 1'b0);
      chk_b("stall_busy", key_busy, 1'b1);
      chk_n("stall_round", rk_round, 4'd4);
      chk_b("stall_done", key_done, 1'b0);
    end
    EN = 1'b1;
    tick();
    chk_n("stall_r5", rk_round, 4'd5);
    chk_b("stall_v5", rk_valid, 1'b1);
    repeat (4) tick();
    chk_b("stall_done13", key_done, 1'b0);
    tick();
    chk_b("stall_done14", key_done, 1'b1);
    chk_k("stall_k10", rk_out, FIPS_K10);
    tick();

    // Start with EN=0 is ignored
    EN = 1'b0; key_start = 1'b1; cipher_key_in = 128'h0;
    tick(); tick();
    chk_b("en0_busy", key_busy, 1'b0);
    chk_b("en0_valid", rk_valid, 1'b0);
    chk_b("en0_kval", key_valid, 1'b1);
    chk_k("en0_rk10", round_key_10, FIPS_K10);
    key_start = 1'b0; EN = 1'b1;

    // Second start at T+5
    cipher_key_in = FIPS_KEY; key_start = 1'b1;
    tick(); key_start = 1'b0;
    repeat (4) tick();
    cipher_key_in = 128'h0; key_start = 1'b1;
    tick(); key_start = 1'b0;
`ifdef AES_KEYEXP_ABORT_EN
    chk_n("abort_r0", rk_round, 4'd0);
    chk_k("abort_k0", rk_out, 128'h0);
    repeat (5) tick();
    chk_b("abort_no_done", key_done, 1'b0);
    chk_b("abort_kval", key_valid, 1'b0);
    repeat (5) tick();
    chk_k("abort_k10", rk_out, ZERO_K10);
    chk_b("abort_done", key_done, 1'b1);
    chk_k("abort_rk10_prior", round_key_10, FIPS_K10);
    tick();
    chk_k("abort_rk10", round_key_10, ZERO_K10);
    chk_b("abort_kval_set", key_valid, 1'b1);
`else
    chk_n("busy_start_r5", rk_round, 4'd5);
    repeat (5) tick();
    chk_k("busy_start_k10", rk_out, FIPS_K10);
    chk_b("busy_start_done", key_done, 1'b1);
    tick();
    chk_k("busy_start_rk10", round_key_10, FIPS_K10);
    chk_b("busy_start_kval", key_valid, 1'b1);
`endif

    // Reset mid-expansion at T+6
    cipher_key_in = FIPS_KEY; key_start = 1'b1;
    tick(); key_start = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    reset_n = 1'b1;
    tick();
    cipher_key_in = 128'h0; key_start = 1'b1;
    tick(); key_start = 1'b0;
    repeat (10) tick();
    chk_k("postrst_k10", rk_out, ZERO_K10);
    chk_b("postrst_done", key_done, 1'b1);
    tick();

    // Back-to-back: start on done cycle ignored, start at T+12 accepted
    cipher_key_in = FIPS_KEY; key_start = 1'b1;
    tick(); key_start = 1'b0;
    repeat (10) tick();
    chk_b("b2b_done1", key_done, 1'b1);
    cipher_key_in = 128'h0;
`ifndef AES_KEYEXP_ABORT_EN
    key_start = 1'b1;
`endif
    tick();
    chk_b("b2b_busy12", key_busy, 1'b0);
    chk_b("b2b_valid12", rk_valid, 1'b0);
    chk_k("b2b_rk10", round_key_10, FIPS_K10);
    key_start = 1'b1;
    tick(); key_start = 1'b0;
    chk_n("b2b_r0", rk_round, 4'd0);
    chk_k("b2b_k0", rk_out, 128'h0);
    repeat (10) tick();
    chk_k("b2b_k10", rk_out, ZERO_K10);
    chk_b("b2b_done2", key_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
Iterative AES-128 key schedule placed directly upstream of the AES core. Expands `cipher_key_in` at one round per cycle and streams round keys K0..K10 to the core. Captures K10 into `round_key_10`, which the core's decipher path consumes. Holds the result until the next accepted start.

Parameters:
- NR, 10, number of rounds. Only 10 is legal; an elaboration-time check fails on any other value.
- KEY_W, 128, key and round-key width. Fixed at 128.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- EN, input, 1, global enable; 0 stalls the block.
- cipher_key_in, input, 128, cipher key. Bits [127:96] are w0, and byte [127:120] is the first key byte.
- key_start, input, 1, start request; sampled when EN=1 and key_busy=0.
- key_busy, output, 1, expansion in progress.
- rk_valid, output, 1, rk_out / rk_round carry a valid round key this cycle.
- rk_out, output, 128, current round key.
- rk_round, output, 4, index (0..10) of rk_out.
- key_done, output, 1, one-cycle pulse coincident with rk_round=10.
- round_key_10, output, 128, registered K10 of the last completed expansion.
- key_valid, output, 1, round_key_10 holds a completed expansion.

Behaviour:
- Reset (async assert, synchronous-style release on clk): all outputs go to 0. This covers key_busy, rk_valid, rk_out, rk_round, key_done, round_key_10 and key_valid. FSM goes to IDLE. Reset mid-expansion aborts it and clears key_valid.
- FSM states: IDLE and EXPAND.
- IDLE:
  - If EN=1 and key_start=1 in cycle T, register cipher_key_in as the working key, set round counter=0 and Rcon=8'h01, then go to EXPAND.
  - key_valid is cleared in the same edge.
- EXPAND, each cycle with EN=1:
  - Outputs registered: rk_out = working key, rk_round = counter, rk_valid = 1, key_busy = 1.
  - Next key: temp = SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Rcon' = xtime(Rcon): left shift; XOR 8'h1B if bit7 was set. Sequence: 01,02,04,08,10,20,40,80,1B,36.
- Timing:
  - K0 appears at T+1 and Ki at T+1+i. K10 appears at T+11 with key_done=1.
  - round_key_10 <= K10 and key_valid <= 1 on the edge ending T+11.
  - FSM returns to IDLE; key_busy=0 from T+12.
- Total latency: 11 cycles from accepted start to key_done.
- Outside valid cycles rk_valid=0. rk_out and rk_round hold their last values.
- Stall:
  - EN=0 freezes the FSM, counter, Rcon and working key.
  - rk_valid=0 and key_done=0 during stalled cycles. key_busy holds.
  - Resuming re-presents the same Ki that was pending, so no key is skipped or duplicated.
- key_start with EN=0 is ignored.
- key_start while key_busy=1 is ignored, unless the optional feature is enabled.
- key_start on the key_done cycle (T+11) is ignored. The earliest next accepted start is T+12.
- S-box: internal 256-entry combinational table. Four instances serve SubWord. Single-cycle combinational path from working key to next-key register.
- Counter: 4-bit, saturates at 10. It never wraps inside EXPAND.

Optional Feature:
Macro `AES_KEYEXP_ABORT_EN`.
- Defined: key_start=1 with EN=1 while key_busy=1 (including the key_done cycle) restarts expansion.
  - cipher_key_in is reloaded, the counter goes to 0 and Rcon to 01.
  - The next cycle shows rk_round=0 of the new key.
  - key_done for the aborted key never fires. round_key_10 keeps its prior value. key_valid stays 0.
- Undefined: starts while busy are ignored as specified above.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start at T:
  - T+1: rk_out=K0=key.
  - T+2: a0fafe1788542cb123a339392a6c7605.
  - T+11: d014f9a8c9ee2589e13f0cc8b6630ca6 with key_done=1.
  - round_key_10 and key_valid=1 from T+12.
- All-zero key: K1=62636363626363636263636362636363, K10=b4ef5bcb3e92e21123e951cf6f8f188e. Rcon steps through 1B and 36.
- EN dropped for 3 cycles after K4: rk_valid=0 for those cycles. K5 appears on resume, and key_done is delayed exactly 3 cycles to T+14.
- Second key_start at T+5 without the macro: ignored, and K10 matches the first key. With the macro: restart, K0 of the new key at T+6, key_done at T+16.
- reset_n asserted at T+6:
  - All outputs 0 immediately.
  - key_valid=0.
  - After release, a new start produces correct K10 in 11 cycles.
- Back-to-back: start at T, start at T+11 ignored, start at T+12 accepted → key_done at T+23.
